// File: rtl/timer_pkg.sv
// Shared types and defaults for the stopwatch control block.
package timer_pkg;

  // One count tick per second at a 50 MHz system clock.
  localparam int TICK_DIV_DEFAULT = 50_000_000;
  localparam int DIV_W_DEFAULT    = 26;

  // Control FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // One bit per operator button event.
  typedef struct packed {
    logic clear;
    logic stop;
    logic start;
    logic load;
  } events_t;

  // Keep only the highest-priority event (clear > stop > start > load).
  // Lower-priority events in the same cycle are dropped entirely.
  function automatic events_t prioritize(events_t raw);
    events_t p;
    p = '0;
    if (raw.clear) begin
      p.clear = 1'b1;
    end else if (raw.stop) begin
      p.stop = 1'b1;
    end else if (raw.start) begin
      p.start = 1'b1;
    end else if (raw.load) begin
      p.load = 1'b1;
    end
    return p;
  endfunction

endpackage

// File: rtl/bcd_timer_ctrl_if.sv
// Button, counter-chain and status signals between the stopwatch top level
// and the timer control FSM.
interface bcd_timer_ctrl_if;

  logic btn_start;
  logic btn_stop;
  logic btn_clear;
  logic btn_load;
  logic cnt_9;
  logic cnt_enb;
  logic cnt_rst;
  logic cnt_ld;
  logic running;
  logic done;

  // The controller: reads buttons and the 999 flag, drives counter strobes.
  modport master (
    input  btn_start, btn_stop, btn_clear, btn_load, cnt_9,
    output cnt_enb, cnt_rst, cnt_ld, running, done
  );

  // The surrounding stopwatch: drives buttons and the 999 flag.
  modport slave (
    output btn_start, btn_stop, btn_clear, btn_load, cnt_9,
    input  cnt_enb, cnt_rst, cnt_ld, running, done
  );

endinterface

// File: rtl/bcd_timer_ctrl_edge_det.sv
// Rising-edge detector for one synchronous button level.
// A button that is already high when reset releases produces no event:
// armed_q stays low for the first cycle after reset so the history
// register can capture the level before edges are reported.
module edge_det (
  input  logic ck,
  input  logic rst_s,
  input  logic d,
  output logic rise
);

  logic d_q;
  logic armed_q;

  // Capture last cycle's level and arm the detector one cycle after reset.
  always_ff @(posedge ck) begin
    if (rst_s) begin
      d_q     <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      d_q     <= d;
      armed_q <= 1'b1;
    end
  end

  assign rise = d & ~d_q & armed_q;

endmodule

// File: rtl/bcd_timer_ctrl.sv
// Control FSM for the 3-digit BCD stopwatch counter chain.
// Turns button levels into events, divides the clock into count ticks and
// drives the counter's enable/clear/load strobes, stopping at 999.
// TICK_DIV must be at least 2 so cnt_enb can never be high two cycles running.
module bcd_timer_ctrl
  import timer_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int DIV_W    = DIV_W_DEFAULT
) (
  input logic              ck,
  input logic              rst_s,
  bcd_timer_ctrl_if.master bus
);

  // Last prescaler value before it wraps and raises a tick.
  localparam logic [DIV_W-1:0] TERM = DIV_W'(TICK_DIV - 1);

  logic evStartRaw;
  logic evStopRaw;
  logic evClearRaw;
  logic evLoadRaw;

  events_t rawEv;
  events_t ev;

  state_e           state_q;
  state_e           state_d;
  logic [DIV_W-1:0] presc_q;
  logic [DIV_W-1:0] presc_d;
  logic             tick;

  logic cnt_enb_q;
  logic cnt_enb_d;
  logic cnt_rst_q;
  logic cnt_rst_d;
  logic cnt_ld_q;
  logic cnt_ld_d;
  logic running_q;
  logic done_q;

  edge_det u_edge_start (
    .ck    (ck),
    .rst_s (rst_s),
    .d     (bus.btn_start),
    .rise  (evStartRaw)
  );

  edge_det u_edge_stop (
    .ck    (ck),
    .rst_s (rst_s),
    .d     (bus.btn_stop),
    .rise  (evStopRaw)
  );

  edge_det u_edge_clear (
    .ck    (ck),
    .rst_s (rst_s),
    .d     (bus.btn_clear),
    .rise  (evClearRaw)
  );

  edge_det u_edge_load (
    .ck    (ck),
    .rst_s (rst_s),
    .d     (bus.btn_load),
    .rise  (evLoadRaw)
  );

  assign rawEv.clear = evClearRaw;
  assign rawEv.stop  = evStopRaw;
  assign rawEv.start = evStartRaw;
  assign rawEv.load  = evLoadRaw;
  assign ev          = prioritize(rawEv);

  assign tick = (presc_q == TERM);

  // Next state, prescaler and strobe decisions for the current cycle.
  // The prescaler only advances while staying in RUN; it holds across a
  // pause so a resume finishes the partial tick, and is zero elsewhere.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    cnt_enb_d = 1'b0;
    cnt_rst_d = 1'b0;
    cnt_ld_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        presc_d = '0;
        if (ev.clear) begin
          cnt_rst_d = 1'b1;
        end else if (ev.start) begin
          state_d = bus.cnt_9 ? ST_DONE : ST_RUN;
        end else if (ev.load) begin
          cnt_ld_d = 1'b1;
        end
      end

      ST_RUN: begin
        if (ev.clear) begin
          state_d   = ST_IDLE;
          presc_d   = '0;
          cnt_rst_d = 1'b1;
        end else if (ev.stop) begin
          state_d = ST_PAUSE;
        end else if (bus.cnt_9) begin
          state_d = ST_DONE;
          presc_d = '0;
        end else begin
          presc_d   = tick ? '0 : presc_q + DIV_W'(1);
          cnt_enb_d = tick;
        end
      end

      ST_PAUSE: begin
        if (ev.clear) begin
          state_d   = ST_IDLE;
          presc_d   = '0;
          cnt_rst_d = 1'b1;
        end else if (ev.start) begin
          state_d = ST_RUN;
        end
      end

      ST_DONE: begin
        presc_d = '0;
        if (ev.clear) begin
          state_d   = ST_IDLE;
          cnt_rst_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        presc_d = '0;
      end
    endcase
  end

  // State, prescaler and registered outputs; reset overrides everything.
  always_ff @(posedge ck) begin
    if (rst_s) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      cnt_enb_q <= 1'b0;
      cnt_rst_q <= 1'b0;
      cnt_ld_q  <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      cnt_enb_q <= cnt_enb_d;
      cnt_rst_q <= cnt_rst_d;
      cnt_ld_q  <= cnt_ld_d;
      running_q <= (state_d == ST_RUN);
      done_q    <= (state_d == ST_DONE);
    end
  end

  assign bus.cnt_enb = cnt_enb_q;
  assign bus.cnt_rst = cnt_rst_q;
  assign bus.cnt_ld  = cnt_ld_q;
  assign bus.running = running_q;
  assign bus.done    = done_q;

endmodule

// File: doc/bcd_timer_ctrl.md
Name: bcd_timer_ctrl

Overview:
- Control FSM that sequences the 3-digit BCD counter chain for the stopwatch top level.
- Turns operator button levels into edge events and divides the system clock into count ticks.
- Drives the counter's enable, synchronous clear and load inputs.
- Stops the count at 999 instead of letting it wrap to 000, and reports run/done status for LEDs.

Parameters:
- TICK_DIV, 50_000_000, system clocks per count tick (min 2).
- DIV_W, 26, prescaler width; must satisfy 2**DIV_W >= TICK_DIV.

Ports:
- ck  in  1  system clock; all logic on rising edge.
- rst_s  in  1  synchronous active-high reset.
- btn_start  in  1  start/resume button, synchronous level, active-high.
- btn_stop  in  1  pause button, synchronous level.
- btn_clear  in  1  clear button, synchronous level.
- btn_load  in  1  preset-load button, synchronous level.
- cnt_9  in  1  level from counter chain, high while display reads 999.
- cnt_enb  out  1  counter enable, one-cycle pulse per tick.
- cnt_rst  out  1  counter synchronous clear, one-cycle pulse.
- cnt_ld  out  1  counter load strobe, one-cycle pulse.
- running  out  1  high in RUN.
- done  out  1  high in DONE.

Behaviour:
- Reset (rst_s=1 at an edge):
  - state=IDLE; prescaler=0; button history regs=0.
  - All outputs 0 the following cycle. Reset has priority over everything.
- Edge detect:
  - Each button is registered; ev_x = btn_x & ~btn_x_q.
  - A held button generates exactly one event.
  - A button already high when reset releases generates no event.
- Event priority in the same cycle: clear > stop > start > load.
  - Lower-priority events in that cycle are dropped.
- States: IDLE, RUN, PAUSE, DONE (encoding in package).
- IDLE:
  - ev_start -> RUN, prescaler=0. If cnt_9=1 at that moment -> DONE instead.
  - ev_load -> stay IDLE, cnt_ld=1 for one cycle.
  - ev_clear -> stay, cnt_rst=1.
- RUN:
  - Prescaler increments each cycle; at TICK_DIV-1 it wraps to 0 and raises tick.
  - cnt_enb is registered from tick, so the first pulse occurs TICK_DIV cycles after the start edge is seen.
  - ev_stop -> PAUSE, prescaler frozen; no cnt_enb in the cycle after.
  - ev_clear -> IDLE, cnt_rst=1, prescaler=0.
  - cnt_9=1 -> DONE with no further cnt_enb. Gating uses the current cnt_9, so a tick coincident with cnt_9 is suppressed and 999 never wraps.
- PAUSE:
  - ev_start -> RUN, prescaler resumes from its held value (no restart of the partial tick).
  - ev_clear -> IDLE + cnt_rst.
  - ev_load ignored.
- DONE:
  - Holds 999.
  - ev_clear -> IDLE + cnt_rst.
  - ev_start and ev_stop ignored.
- Strobes:
  - cnt_rst, cnt_ld and cnt_enb are registered and mutually exclusive.
  - None is ever high for 2 consecutive cycles.
- Status: running = (state==RUN), done = (state==DONE), both registered.
- Width rule: prescaler compare uses TICK_DIV-1 sized to DIV_W; no truncation warnings allowed.

Decomposition:
- Package timer_pkg: state enum, state encoding, default TICK_DIV.
- Sub-module edge_det: 1-bit, ports ck, rst_s, d, rise. Instantiated four times.
- FSM and prescaler stay in bcd_timer_ctrl.

Test Plan:
1. TICK_DIV=4, reset, pulse start -> running=1 next cycle; cnt_enb pulses at cycles 4, 8, 12 after the start edge, each 1 cycle wide.
2. Run, stop mid-tick (prescaler=2), wait 20 cycles, start -> no cnt_enb while paused; next cnt_enb exactly 2 cycles after resume.
3. Drive cnt_9=1 during RUN coincident with a tick -> cnt_enb stays 0, done=1 next cycle; later start and stop ignored; clear -> cnt_rst one pulse, state IDLE.
4. Assert start, stop and clear on the same edge in RUN -> single cnt_rst pulse, IDLE, no cnt_enb.
5. Hold btn_start high for 50 cycles from IDLE -> exactly one transition; IDLE load pulse -> cnt_ld=1 for 1 cycle; load in RUN/PAUSE -> no cnt_ld.
6. rst_s asserted mid-RUN with a tick due -> all outputs 0 next cycle, no cnt_enb; state IDLE after release.
